// File: rtl/spi_slave.sv
// spi_slave: 16-bit SPI target, modes 0-3, oversampled in the clk domain.
// One word in and one word out per chip-select, valid/ready local side.
module spi_slave #(
  parameter int SPI_MODE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        tx_valid,
  input  logic [15:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic        frame_err,
  output logic        tx_underrun
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic        sclk_s, cs_s, mosi_s;
  logic        lead, trail;
  logic        sample_e, shift_e;
  logic        cs_fall, cs_rise;

  logic        load, do_sample, do_shift;
  logic        last, abort, to_idle;

  logic [15:0] hold_data;
  logic        hold_full;
  logic [15:0] tx_sh;
  logic [14:0] rx_sh;
  logic [3:0]  bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= CPOL;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead     = (sclk_s != CPOL) && (sclk_d == CPOL);
  assign trail    = (sclk_s == CPOL) && (sclk_d != CPOL);
  assign sample_e = CPHA ? trail : lead;
  assign shift_e  = CPHA ? lead : trail;
  assign cs_fall  = !cs_s && cs_d;
  assign cs_rise  = cs_s && !cs_d;

  assign tx_ready = !hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // 16th sample and cs_n rise together: word completes, straight to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nx = ACTIVE;
      ACTIVE: begin
        if (cs_rise)   state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    last      = 1'b0;
    abort     = 1'b0;
    to_idle   = 1'b0;
    unique case (state)
      IDLE: load = cs_fall;
      ACTIVE: begin
        last      = sample_e && (bit_cnt == 4'd15);
        abort     = cs_rise && !last;
        do_sample = sample_e && !abort;
        do_shift  = shift_e && !abort;
        to_idle   = cs_rise;
      end
      DONE: to_idle = cs_rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      if (load) begin
        hold_full   <= 1'b0;
        tx_sh       <= hold_full ? hold_data : 16'h0000;
        tx_underrun <= !hold_full;
        bit_cnt     <= '0;
        if (!CPHA) miso <= hold_full & hold_data[15];
      end
      // accept after load so an empty register can refill in the same cycle
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (do_shift) begin
        miso  <= CPHA ? tx_sh[15] : tx_sh[14];
        tx_sh <= {tx_sh[14:0], 1'b0};
      end
      if (do_sample) begin
        rx_sh   <= {rx_sh[13:0], mosi_s};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (last) begin
        rx_data  <= {rx_sh, mosi_s};
        rx_valid <= 1'b1;
      end
      if (abort) frame_err <= 1'b1;
      if (to_idle) miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench, one slave per SPI mode, bench acts as master.
// Expected words are hand-chosen constants; pulses are counted per instance.
module tb_spi_slave;

  localparam int HALF = 80;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        mosi  = 1'b0;
  logic [3:0]  sclk;
  logic [3:0]  cs_n;
  logic [3:0]  tx_valid;
  logic [15:0] tx_data [4];
  wire  [3:0]  miso;
  wire  [3:0]  tx_ready;
  wire  [3:0]  rx_valid;
  wire  [3:0]  frame_err;
  wire  [3:0]  tx_underrun;
  wire  [15:0] rx_data [4];

  int checks = 0;
  int errors = 0;
  int rxv_cnt [4] = '{default: 0};
  int ferr_cnt [4] = '{default: 0};
  int unr_cnt [4] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .SPI_MODE(g),
      .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .sclk(sclk[g]),
      .cs_n(cs_n[g]),
      .mosi(mosi),
      .miso(miso[g]),
      .tx_valid(tx_valid[g]),
      .tx_data(tx_data[g]),
      .tx_ready(tx_ready[g]),
      .rx_valid(rx_valid[g]),
      .rx_data(rx_data[g]),
      .frame_err(frame_err[g]),
      .tx_underrun(tx_underrun[g])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_valid[k] === 1'b1) rxv_cnt[k]++;
      if (frame_err[k] === 1'b1) ferr_cnt[k]++;
      if (tx_underrun[k] === 1'b1) unr_cnt[k]++;
    end
  end

  task automatic offer(input int m, input logic [15:0] d);
    @(negedge clk);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic xfer(input int m, input logic [15:0] mtx,
                      input int ncyc, input bit hold_cs,
                      output logic [15:0] mrx);
    logic        cpol, cpha;
    logic [15:0] ms;
    cpol = (m >= 2);
    cpha = (m == 1) || (m == 3);
    ms   = mtx;
    mrx  = '0;
    cs_n[m] = 1'b0;
    if (!cpha) begin mosi = ms[15]; ms = ms << 1; end
    #(HALF);
    for (int i = 0; i < ncyc; i++) begin
      if (cpha) begin mosi = ms[15]; ms = ms << 1; end
      sclk[m] = ~cpol;
      if (!cpha && i < 16) mrx = {mrx[14:0], miso[m]};
      #(HALF);
      sclk[m] = cpol;
      if (cpha && i < 16) mrx = {mrx[14:0], miso[m]};
      if (!cpha) begin mosi = ms[15]; ms = ms << 1; end
      #(HALF);
    end
    if (!hold_cs) begin
      cs_n[m] = 1'b1;
      mosi    = 1'b0;
      #(100);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (miso[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_miso m%0d got %b exp 0", k, miso[k]);
      end
      checks++;
      if (tx_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_tx_ready m%0d got %b exp 1", k, tx_ready[k]);
      end
      checks++;
      if (rx_valid[k] !== 1'b0 || frame_err[k] !== 1'b0 ||
          tx_underrun[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_pulses m%0d got %b%b%b exp 000", k,
                 rx_valid[k], frame_err[k], tx_underrun[k]);
      end
      checks++;
      if (rx_data[k] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_rx_data m%0d got %h exp 0000", k, rx_data[k]);
      end
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_loopback_mode1();
    logic [15:0] mrx;
    int rv0, un0;
    rv0 = rxv_cnt[1];
    un0 = unr_cnt[1];
    offer(1, 16'hA5C3);
    checks++;
    if (tx_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL lb_tx_ready_drop got %b exp 0", tx_ready[1]);
    end
    xfer(1, 16'h3C5A, 16, 1'b0, mrx);
    checks++;
    if (mrx !== 16'hA5C3) begin
      errors++;
      $display("FAIL lb_master_rx got %h exp a5c3", mrx);
    end
    checks++;
    if (rx_data[1] !== 16'h3C5A) begin
      errors++;
      $display("FAIL lb_slave_rx got %h exp 3c5a", rx_data[1]);
    end
    checks++;
    if (rxv_cnt[1] - rv0 !== 1) begin
      errors++;
      $display("FAIL lb_rx_valid_cycles got %0d exp 1", rxv_cnt[1] - rv0);
    end
    checks++;
    if (unr_cnt[1] - un0 !== 0) begin
      errors++;
      $display("FAIL lb_underrun got %0d exp 0", unr_cnt[1] - un0);
    end
    checks++;
    if (tx_ready[1] !== 1'b1 || miso[1] !== 1'b0) begin
      errors++;
      $display("FAIL lb_idle got ready=%b miso=%b exp 1 0",
               tx_ready[1], miso[1]);
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] mrx;
    int rv0, fe0;
    rv0 = rxv_cnt[1];
    fe0 = ferr_cnt[1];
    offer(1, 16'hBEEF);
    xfer(1, 16'h5555, 9, 1'b0, mrx);
    checks++;
    if (ferr_cnt[1] - fe0 !== 1) begin
      errors++;
      $display("FAIL ferr_pulse got %0d exp 1", ferr_cnt[1] - fe0);
    end
    checks++;
    if (rxv_cnt[1] - rv0 !== 0) begin
      errors++;
      $display("FAIL ferr_no_rx_valid got %0d exp 0", rxv_cnt[1] - rv0);
    end
    checks++;
    if (rx_data[1] !== 16'h3C5A) begin
      errors++;
      $display("FAIL ferr_rx_kept got %h exp 3c5a", rx_data[1]);
    end
    offer(1, 16'h0F0F);
    xfer(1, 16'h1234, 16, 1'b0, mrx);
    checks++;
    if (rx_data[1] !== 16'h1234 || mrx !== 16'h0F0F) begin
      errors++;
      $display("FAIL ferr_next_frame got rx=%h mrx=%h exp 1234 0f0f",
               rx_data[1], mrx);
    end
  endtask

  task automatic test_modes();
    logic [15:0] mrx;
    logic [15:0] w [2];
    int rv0;
    w[0] = 16'h8001;
    w[1] = 16'h7FFE;
    for (int m = 0; m < 4; m++) begin
      if (m == 1) continue;
      for (int j = 0; j < 2; j++) begin
        rv0 = rxv_cnt[m];
        offer(m, w[j]);
        xfer(m, w[1-j], 16, 1'b0, mrx);
        checks++;
        if (mrx !== w[j]) begin
          errors++;
          $display("FAIL mode%0d_master_rx got %h exp %h", m, mrx, w[j]);
        end
        checks++;
        if (rx_data[m] !== w[1-j]) begin
          errors++;
          $display("FAIL mode%0d_slave_rx got %h exp %h",
                   m, rx_data[m], w[1-j]);
        end
        checks++;
        if (rxv_cnt[m] - rv0 !== 1) begin
          errors++;
          $display("FAIL mode%0d_rx_valid got %0d exp 1",
                   m, rxv_cnt[m] - rv0);
        end
        checks++;
        if (miso[m] !== 1'b0) begin
          errors++;
          $display("FAIL mode%0d_miso_idle got %b exp 0", m, miso[m]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    logic [15:0] mrx;
    int un0;
    un0 = unr_cnt[0];
    xfer(0, 16'h1111, 16, 1'b0, mrx);
    checks++;
    if (unr_cnt[0] - un0 !== 1) begin
      errors++;
      $display("FAIL underrun_pulse got %0d exp 1", unr_cnt[0] - un0);
    end
    checks++;
    if (mrx !== 16'h0000) begin
      errors++;
      $display("FAIL underrun_master_rx got %h exp 0000", mrx);
    end
    checks++;
    if (rx_data[0] !== 16'h1111) begin
      errors++;
      $display("FAIL underrun_slave_rx got %h exp 1111", rx_data[0]);
    end
  endtask

  task automatic test_extra_edges();
    logic [15:0] mrx;
    int rv0, fe0;
    rv0 = rxv_cnt[3];
    fe0 = ferr_cnt[3];
    offer(3, 16'hC0DE);
    xfer(3, 16'hABCD, 20, 1'b0, mrx);
    checks++;
    if (rx_data[3] !== 16'hABCD || mrx !== 16'hC0DE) begin
      errors++;
      $display("FAIL extra_data got rx=%h mrx=%h exp abcd c0de",
               rx_data[3], mrx);
    end
    checks++;
    if (rxv_cnt[3] - rv0 !== 1 || ferr_cnt[3] - fe0 !== 0) begin
      errors++;
      $display("FAIL extra_pulses got rv=%0d fe=%0d exp 1 0",
               rxv_cnt[3] - rv0, ferr_cnt[3] - fe0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] mrx;
    offer(1, 16'h1357);
    xfer(1, 16'hAAAA, 8, 1'b1, mrx);
    offer(1, 16'h9999);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (miso[1] !== 1'b0 || tx_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_outputs got miso=%b ready=%b exp 0 1",
               miso[1], tx_ready[1]);
    end
    checks++;
    if (rx_data[1] !== 16'h0000 || rx_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rx got %h/%b exp 0000/0",
               rx_data[1], rx_valid[1]);
    end
    #19;
    cs_n[1] = 1'b1;
    sclk[1] = 1'b0;
    mosi    = 1'b0;
    #20;
    rst_n = 1'b1;
    #100;
    offer(1, 16'h2468);
    xfer(1, 16'hFFFF, 16, 1'b0, mrx);
    checks++;
    if (rx_data[1] !== 16'hFFFF || mrx !== 16'h2468) begin
      errors++;
      $display("FAIL rstmid_next got rx=%h mrx=%h exp ffff 2468",
               rx_data[1], mrx);
    end
  endtask

  initial begin
    sclk     = 4'b1100;
    cs_n     = 4'hF;
    tx_valid = 4'h0;
    for (int k = 0; k < 4; k++) tx_data[k] = 16'h0000;
    test_reset();
    test_loopback_mode1();
    test_frame_err();
    test_modes();
    test_underrun();
    test_extra_edges();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Responder end of the 16-bit SPI link driven by `spi_master`: oversamples an external SCLK/CS_N/MOSI in the `clk` domain, shifts one 16-bit MSB-first word in and one out per chip-select assertion, and presents both through valid/ready style ports to local logic. It sits on the peripheral (FPGA-as-target) side of the board link and supports all four SPI modes via a parameter.

## Interface
- `SPI_MODE`, 1, SPI mode 0-3; CPOL = (mode 2 or 3), CPHA = (mode 1 or 3).
- `SYNC_STAGES`, 2, synchronizer depth for sclk/cs_n/mosi (≥2).
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low. Clock is `clk`.
- `sclk` input 1: SPI clock from master, asynchronous to `clk`.
- `cs_n` input 1: chip select, active low, asynchronous.
- `mosi` input 1: serial data in.
- `miso` output 1: serial data out, registered.
- `tx_valid` input 1: local word offered for next frame.
- `tx_data` input 16: word to transmit.
- `tx_ready` output 1: holding register empty.
- `rx_valid` output 1: one-cycle pulse, `rx_data` holds a complete received word.
- `rx_data` output 16: last complete received word.
- `frame_err` output 1: one-cycle pulse on aborted frame (cs_n rose before 16 samples).
- `tx_underrun` output 1: one-cycle pulse when a frame starts with empty holding register.

## Operation
- Reset values: `miso`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `frame_err`=0, `tx_underrun`=0; holding register empty; state IDLE; synchronizers preset sclk=CPOL, cs_n=1, mosi=0.
- sclk, cs_n, mosi each pass through SYNC_STAGES flops; one extra register per signal for edge detection.
- Leading edge = synced sclk leaves CPOL level; trailing edge = returns to CPOL. Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the other.
- TX holding register: loads `tx_data` when `tx_valid & tx_ready`; `tx_ready` drops the next cycle and rises the cycle after the holding word is moved into the shift register.
- States:
  - IDLE: `miso`=0; on synced cs_n falling edge -> load TX shift register from holding register (or 16'h0000 plus `tx_underrun` pulse if empty), clear bit counter -> ACTIVE. If CPHA=0, `miso` = bit15 on the same load cycle.
  - ACTIVE: sample edge: shift synced mosi into RX shift register LSB, count++. Shift edge: CPHA=0 drives next lower bit, CPHA=1 drives current MSB-pointer bit then decrements (first shift edge drives bit15). On 16th sample -> `rx_data` <= word, `rx_valid` pulse -> DONE.
  - DONE: all further sclk edges ignored, `miso` holds last bit; synced cs_n rising -> IDLE.
  - ACTIVE with synced cs_n rising -> IDLE, `frame_err` pulse, `rx_data` unchanged, no `rx_valid`.
- Exactly one frame per cs_n assertion; a new frame requires cs_n high for ≥ SYNC_STAGES+2 clk cycles.
- Simultaneous cs_n rise and 16th sample edge in same cycle: the sample wins; the word completes (`rx_valid`), no `frame_err`.
- `tx_valid` while frame in progress: accepted into holding register if empty; used by next frame, never the current one.
- rst_n asserted mid-frame: everything returns to reset values immediately; the partial word is discarded; the block waits for the next cs_n falling edge.

## Timing
- Requirement: sclk high and low phases each ≥ 4 `clk` periods; cs_n setup to first sclk edge ≥ 4 `clk` periods.
- Pin-to-internal edge latency: SYNC_STAGES+1 clk cycles (3 at default).
- `miso` changes SYNC_STAGES+2 clk cycles after the pin shift edge (4 at default), inside the half period.
- `rx_valid` rises SYNC_STAGES+2 clk cycles after the 16th sampling edge at the pin; width exactly 1 cycle.
- `frame_err` rises SYNC_STAGES+2 clk cycles after the cs_n rising edge at the pin.

## Test plan
- Mode 1 loopback with `spi_master` (HALF_CLK_DIV=4), bench-driven cs_n, slave tx 16'hA5C3, master tx 16'h3C5A -> slave `rx_data`=16'h3C5A with one `rx_valid` pulse; master `o_data`=16'hA5C3.
- Modes 0, 2, 3 with words 16'h8001 / 16'h7FFE -> exact data both directions; `miso` idle 0 outside cs_n.
- No `tx_valid` before cs_n fall -> `tx_underrun` pulse, master receives 16'h0000.
- cs_n raised after 9 sclk cycles -> `frame_err` pulse, no `rx_valid`, `rx_data` retains prior 16'h3C5A; the next full frame of 16'h1234 is received correctly.
- 20 sclk cycles under one cs_n -> only first 16 bits captured, single `rx_valid`, extra edges ignored.
- rst_n pulsed after bit 7 -> all outputs at reset values; a following full frame of 16'hFFFF is received correctly.
